pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter and fetch controller for the IFU. It sits directly upstream of `inc16bit`: it owns the PC register, drives the incrementer's input, and takes the incremented value back as the sequential next-PC. It issues one-outstanding instruction-memory requests and buffers the returned words, with their PCs, in a 2-entry queue for decode. Redirects (branch/jump) flush the queue and squash any in-flight fetch.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pc_out` out 16: current PC; drives `inc16bit` input.
- `pc_inc` in 16: `inc16bit` output; must equal `pc_out + 1` mod 2^16 in the same cycle (combinational).
- `redirect` in 1: load new PC this cycle.
- `redirect_pc` in 16: target PC, sampled when `redirect` = 1.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 16: fetch address; equals `pc_out`.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 16: instruction word.
- `inst_valid` out 1: queue head valid.
- `inst` out 16: queue head instruction.
- `inst_pc` out 16: PC of queue head.
- `inst_ready` in 1: decode consumes the head when `inst_valid` = 1.

## Operation
- State machine: FETCH, WAIT.
- FETCH:
  - `imem_req` = (`count + 0 < 2`), i.e. the queue has a free slot.
  - On `imem_req && imem_gnt`: latch `req_pc <= pc_out`, update `pc <= pc_inc`, and go to WAIT.
  - `imem_rvalid` is ignored in FETCH.
- WAIT:
  - `imem_req` = 0.
  - On `imem_rvalid`: push {`imem_rdata`, `req_pc`} unless `squash` = 1, clear `squash`, and go to FETCH.
- Redirect (any state), with priority over everything else:
  - `pc <= redirect_pc`.
  - Queue cleared (`count <= 0`); a pop in the same cycle is discarded.
  - If in WAIT, or if in FETCH with `imem_gnt` = 1 that cycle: set `squash <= 1`, so the pending response is dropped. The grant still moves FETCH to WAIT.
  - A redirect in FETCH with a grant does not advance `pc` to `pc_inc`.
- Queue: 2-entry FIFO, with `count` ranging 0..2.
  - Push: accepted rvalid in WAIT.
  - Pop: `inst_valid && inst_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - The credit rule (issue only when `count < 2`) guarantees a free slot at every push. An overflow is a design error; the bench asserts it never occurs.
- Head outputs: `inst_valid` = (`count != 0`); `inst`/`inst_pc` come from the head entry. There is no bypass from `imem_rdata`.
- Arithmetic: PC is 16-bit and wraps, FFFF -> 0000 via `pc_inc`. There is no internal adder; sequential next-PC is always `pc_inc`.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - `pc` = `RESET_PC`, state = FETCH, `count` = 0, `squash` = 0.
  - Queue storage and `req_pc` = 0.
  - Outputs while in reset: `imem_req` = 0, `inst_valid` = 0, `inst` = 0, `inst_pc` = 0, `pc_out`/`imem_addr` = `RESET_PC`.
- `imem_req` is masked by `rst_n` and rises in the first cycle with `rst_n` = 1.
- Reset mid-WAIT: the outstanding response is abandoned. A late `imem_rvalid` arriving in FETCH is ignored.
- Latency:
  - Grant at cycle N and rvalid at N+k (k >= 1) give `inst_valid` at N+k+1.
  - The next `imem_req` is asserted at N+k+1.
  - Peak throughput is one fetch per 2 cycles with k = 1.
- `redirect` at cycle N gives `pc_out` = `redirect_pc` and `inst_valid` = 0 at N+1. `imem_req` for the target is asserted at N+1 if in FETCH; otherwise it is asserted the cycle after the squashed rvalid.
- Redirect in the same cycle as rvalid in WAIT: the response is dropped, state goes to FETCH, `pc` = `redirect_pc`.
- `imem_addr`/`imem_req` are stable while `imem_req` = 1 and `imem_gnt` = 0, unless `redirect`.

## Test plan
- Reset with `RESET_PC` = 16'h0000, `rst_n` low for 3 cycles -> `imem_req` = 0, `inst_valid` = 0, `pc_out` = 0000. `imem_req` = 1 with `imem_addr` = 0000 in the first cycle after release.
- Streaming with gnt immediate, rvalid 1 cycle later, `inst_ready` = 1, and rdata = addr ^ 16'hA5A5 -> addresses 0000, 0001, 0002, 0003 in order. Each `inst` = addr ^ A5A5 and `inst_pc` = addr, appearing one cycle after its rvalid.
- Backpressure with `inst_ready` = 0 -> after two fills, `count` = 2, `imem_req` stays 0, and `pc_out` holds 0002. Raising `inst_ready` pops 0000 then 0001, and the fetch of 0002 resumes.
- Redirect to 16'h0040 while in WAIT for 0003 -> the 0003 rvalid is discarded, the queue is empty the cycle after the redirect, the next `imem_addr` = 0040, and the following `inst_pc` = 0040.
- Redirect in the same cycle as `imem_gnt` for 0005, target 16'h1234 -> the 0005 response is squashed, `pc_out` = 1234 (not 0006), and the next request is 1234.
- Wrap and reset: `RESET_PC` = 16'hFFFF -> fetches FFFF then 0000. Then `rst_n` = 0 during WAIT, followed by a late rvalid -> no push, and `pc_out` = FFFF.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// IFU program counter and fetch controller: one outstanding imem
// request, 2-entry instruction queue, redirect flush and squash.
module pc_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc_out,
    input  logic [15:0] pc_inc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        inst_ready
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_pc_q, req_pc_d;
    logic        squash_q, squash_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] data0_q, data0_d, data1_q, data1_d;
    logic [15:0] ipc0_q, ipc0_d, ipc1_q, ipc1_d;

    logic        grant;
    logic        rsp;
    logic        push;
    logic        pop;
    logic        wr_hi;
    logic [1:0]  wr_idx;

    assign pc_out     = pc_q;
    assign imem_addr  = pc_q;
    assign inst_valid = (count_q != 2'd0);
    assign inst       = data0_q;
    assign inst_pc    = ipc0_q;

    always_comb begin
        imem_req = rst_n && (state_q == S_FETCH) && (count_q < 2'd2);
        grant    = imem_req && imem_gnt;
        rsp      = (state_q == S_WAIT) && imem_rvalid;
        push     = rsp && !squash_q && !redirect;
        pop      = inst_valid && inst_ready && !redirect;
        wr_idx   = count_q - {1'b0, pop};
        wr_hi    = (wr_idx != 2'd0);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        squash_d = squash_q;
        count_d  = count_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        ipc0_d   = ipc0_q;
        ipc1_d   = ipc1_q;

        unique case (state_q)
            S_FETCH: begin
                if (grant) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_inc;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    squash_d = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (pop) begin
            data0_d = data1_q;
            ipc0_d  = ipc1_q;
        end
        if (push) begin
            if (wr_hi) begin
                data1_d = imem_rdata;
                ipc1_d  = req_pc_q;
            end else begin
                data0_d = imem_rdata;
                ipc0_d  = req_pc_q;
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Redirect wins; a response still owed to us must be dropped,
        // unless it is arriving right now and so is already consumed.
        if (redirect) begin
            pc_d    = redirect_pc;
            count_d = 2'd0;
            if ((state_q == S_WAIT && !imem_rvalid) || grant) begin
                squash_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= 16'h0000;
            squash_q <= 1'b0;
            count_q  <= 2'd0;
            data0_q  <= 16'h0000;
            data1_q  <= 16'h0000;
            ipc0_q   <= 16'h0000;
            ipc1_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            squash_q <= squash_d;
            count_q  <= count_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            ipc0_q   <= ipc0_d;
            ipc1_q   <= ipc1_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: streaming, backpressure, redirects,
// PC wrap and reset during an outstanding fetch.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] pc_out, pc_inc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic [15:0] inst, inst_pc;
    logic        inst_ready;

    logic        w_rst_n;
    logic [15:0] w_pc_out, w_pc_inc;
    logic        w_redirect;
    logic [15:0] w_redirect_pc;
    logic        w_imem_req;
    logic [15:0] w_imem_addr;
    logic        w_imem_gnt, w_imem_rvalid;
    logic [15:0] w_imem_rdata;
    logic        w_inst_valid;
    logic [15:0] w_inst, w_inst_pc;
    logic        w_inst_ready;

    assign pc_inc   = pc_out + 16'd1;
    assign w_pc_inc = w_pc_out + 16'd1;

    pc_fetch_ctrl #(.RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .pc_out(pc_out), .pc_inc(pc_inc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    pc_fetch_ctrl #(.RESET_PC(16'hFFFF)) u_dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .pc_out(w_pc_out), .pc_inc(w_pc_inc),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_gnt(w_imem_gnt), .imem_rvalid(w_imem_rvalid),
        .imem_rdata(w_imem_rdata),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
        .inst_ready(w_inst_ready)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 after the edge, checks 2 after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_main();
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0;
        w_rst_n = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
        w_imem_gnt = 1'b0; w_imem_rvalid = 1'b0; w_imem_rdata = '0;
        w_inst_ready = 1'b0;

        // Reset held for three edges
        tick();
        settle();
        chk("rst_req", imem_req, 0);
        chk("rst_ivalid", inst_valid, 0);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 16'h0000);

        // Streaming: gnt immediate, rvalid one cycle later
        inst_ready = 1'b1;
        for (int a = 0; a < 4; a++) begin
            imem_gnt = 1'b1; imem_rvalid = 1'b0;
            settle();
            chk("st_req", imem_req, 1);
            chk("st_addr", imem_addr, a);
            if (a > 0) begin
                chk("st_ivalid", inst_valid, 1);
                chk("st_inst", inst, (a - 1) ^ 16'hA5A5);
                chk("st_inst_pc", inst_pc, a - 1);
            end
            tick();
            imem_gnt = 1'b0; imem_rvalid = 1'b1;
            imem_rdata = 16'(a) ^ 16'hA5A5;
            settle();
            chk("st_wait_req", imem_req, 0);
            chk("st_wait_ivalid", inst_valid, 0);
            tick();
        end
        idle_main();
        settle();
        chk("st_last_inst", inst, 16'h0003 ^ 16'hA5A5);
        chk("st_last_pc", inst_pc, 16'h0003);
        chk("st_next_addr", imem_addr, 16'h0004);

        // Backpressure from a fresh reset
        rst_n = 1'b0; inst_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hA5A5;
        tick();
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        settle();
        chk("bp_one_valid", inst_valid, 1);
        chk("bp_one_req", imem_req, 1);
        chk("bp_one_addr", imem_addr, 16'h0001);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hA5A4;
        tick();
        imem_rvalid = 1'b0;
        settle();
        chk("bp_full_req", imem_req, 0);
        chk("bp_full_pc", pc_out, 16'h0002);
        chk("bp_head_pc", inst_pc, 16'h0000);
        tick();
        settle();
        chk("bp_hold_req", imem_req, 0);
        chk("bp_hold_pc", pc_out, 16'h0002);
        inst_ready = 1'b1;
        settle();
        chk("bp_pop0_inst", inst, 16'hA5A5);
        chk("bp_pop0_pc", inst_pc, 16'h0000);
        tick();
        imem_gnt = 1'b1;
        settle();
        chk("bp_pop1_inst", inst, 16'hA5A4);
        chk("bp_pop1_pc", inst_pc, 16'h0001);
        chk("bp_resume_req", imem_req, 1);
        chk("bp_resume_addr", imem_addr, 16'h0002);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hA5A7;
        settle();
        chk("bp_empty", inst_valid, 0);
        tick();
        imem_rvalid = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b0;
        settle();
        chk("bp_f2_pc", inst_pc, 16'h0002);
        chk("bp_f3_addr", imem_addr, 16'h0003);
        tick();

        // Redirect to 0040 while waiting on 0003, with one entry queued
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        settle();
        chk("rd_pre_valid", inst_valid, 1);
        tick();
        redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hA5A6;
        settle();
        chk("rd_flush", inst_valid, 0);
        chk("rd_pc", pc_out, 16'h0040);
        chk("rd_wait_req", imem_req, 0);
        tick();
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        settle();
        chk("rd_drop", inst_valid, 0);
        chk("rd_req", imem_req, 1);
        chk("rd_addr", imem_addr, 16'h0040);
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h40 ^ 16'hA5A5;
        tick();
        imem_rvalid = 1'b0;
        settle();
        chk("rd_tgt_pc", inst_pc, 16'h0040);
        chk("rd_tgt_inst", inst, 16'h40 ^ 16'hA5A5);

        // Redirect to 0005 in FETCH without grant, then grant+redirect
        inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0005;
        tick();
        redirect_pc = 16'h1234; imem_gnt = 1'b1;
        settle();
        chk("rg_addr", imem_addr, 16'h0005);
        chk("rg_flush", inst_valid, 0);
        tick();
        redirect = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 16'hBEEF;
        settle();
        chk("rg_pc", pc_out, 16'h1234);
        chk("rg_wait_req", imem_req, 0);
        tick();
        imem_rvalid = 1'b0;
        settle();
        chk("rg_drop", inst_valid, 0);
        chk("rg_req", imem_req, 1);
        chk("rg_addr2", imem_addr, 16'h1234);
        tick();
        settle();
        chk("rg_stable_req", imem_req, 1);
        chk("rg_stable_addr", imem_addr, 16'h1234);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h5678;
        tick();
        imem_rvalid = 1'b0;
        settle();
        chk("rg_tgt_pc", inst_pc, 16'h1234);
        chk("rg_tgt_inst", inst, 16'h5678);
        tick();
        idle_main();

        // Wrap with RESET_PC = FFFF, then reset during WAIT
        tick();
        w_rst_n = 1'b1; w_imem_gnt = 1'b1;
        settle();
        chk("w_req", w_imem_req, 1);
        chk("w_addr0", w_imem_addr, 16'hFFFF);
        tick();
        w_imem_gnt = 1'b0; w_imem_rvalid = 1'b1; w_imem_rdata = 16'h1111;
        tick();
        w_imem_rvalid = 1'b0; w_imem_gnt = 1'b1; w_inst_ready = 1'b1;
        settle();
        chk("w_inst_pc", w_inst_pc, 16'hFFFF);
        chk("w_inst", w_inst, 16'h1111);
        chk("w_addr1", w_imem_addr, 16'h0000);
        tick();
        w_imem_gnt = 1'b0; w_rst_n = 1'b0;
        settle();
        chk("w_rst_req", w_imem_req, 0);
        tick();
        w_rst_n = 1'b1; w_imem_rvalid = 1'b1; w_imem_rdata = 16'h2222;
        settle();
        chk("w_rst_pc", w_pc_out, 16'hFFFF);
        chk("w_rst_valid", w_inst_valid, 0);
        chk("w_rst_inst", w_inst, 16'h0000);
        chk("w_rst_req2", w_imem_req, 1);
        tick();
        w_imem_rvalid = 1'b0;
        settle();
        chk("w_late_drop", w_inst_valid, 0);
        chk("w_late_pc", w_pc_out, 16'hFFFF);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
